// File: rtl/risc16_seq_if.sv
// Bundle of the memory handshakes and datapath control signals around the
// RiSC-16 control sequencer.
//   master : sequencer side (drives requests, ir, PC/RF controls, status)
//   slave  : environment side (memories, datapath, run control)
interface risc16_seq_if;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        eq;
  logic [15:0] ir;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        err;

  modport master (
    input  run, imem_ack, imem_rdata, dmem_ack, eq,
    output imem_req, dmem_req, dmem_we, ir, pc_en, pc_sel, rf_we, wb_sel,
           halted, err
  );

  modport slave (
    output run, imem_ack, imem_rdata, dmem_ack, eq,
    input  imem_req, dmem_req, dmem_we, ir, pc_en, pc_sel, rf_we, wb_sel,
           halted, err
  );
endinterface

// File: rtl/risc16_seq.sv
// Multi-cycle control sequencer for the RiSC-16 core: fetch, decode, execute,
// memory and write-back, plus PC enable/select, RF and data-memory strobes
// and a memory-request watchdog.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : risc16_seq_if.master (run, imem/dmem handshakes, eq, ir,
//         pc_en/pc_sel, rf_we/wb_sel, halted, err)
module risc16_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  risc16_seq_if.master     bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IW    = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_e;

  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_e            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0] opcode;
  logic       wdog_hit;
  logic       imem_req_c, dmem_req_c, dmem_we_c, pc_en_c, rf_we_c;
  logic       halted_c, err_c;
  logic [1:0] pc_sel_c, wb_sel_c;

  assign opcode   = ir_q[15:13];
  // True on the pending cycle that would bring the counter up to TIMEOUT.
  assign wdog_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

  // State, instruction and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode; the watchdog is cleared in every cycle
  // that is not an unacknowledged request, so it starts at 0 on entry.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cnt_d      = '0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    pc_en_c    = 1'b0;
    pc_sel_c   = 2'b00;
    rf_we_c    = 1'b0;
    wb_sel_c   = 2'b00;
    halted_c   = 1'b0;
    err_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end else if (wdog_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_SW, OP_LW: state_d = S_MEM;
          OP_BEQ: begin
            pc_en_c  = 1'b1;
            pc_sel_c = bus.eq ? 2'b01 : 2'b00;
            state_d  = S_FETCH;
          end
          // jalr with a non-zero immediate field encodes halt.
          OP_JALR: state_d = (ir_q[6:0] == 7'd0) ? S_WB : S_HALT;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (opcode == OP_SW);
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (wdog_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_en_c = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_SW: rf_we_c = 1'b0;
          OP_LW: begin
            rf_we_c  = 1'b1;
            wb_sel_c = 2'b01;
          end
          OP_JALR: begin
            rf_we_c  = 1'b1;
            wb_sel_c = 2'b10;
            pc_sel_c = 2'b10;
          end
          default: rf_we_c = 1'b1;
        endcase
      end
      S_HALT: begin
        halted_c = 1'b1;
        if (bus.run) begin
          pc_en_c = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ERR: err_c = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ir       = ir_q;
  assign bus.imem_req = imem_req_c;
  assign bus.dmem_req = dmem_req_c;
  assign bus.dmem_we  = dmem_we_c;
  assign bus.pc_en    = pc_en_c;
  assign bus.pc_sel   = pc_sel_c;
  assign bus.rf_we    = rf_we_c;
  assign bus.wb_sel   = wb_sel_c;
  assign bus.halted   = halted_c;
  assign bus.err      = err_c;

endmodule

// File: tb/tb_risc16_seq.sv
// Directed self-checking bench for risc16_seq (TIMEOUT=4).
module tb_risc16_seq;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  risc16_seq_if bus ();

  risc16_seq #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output vector: imem_req dmem_req dmem_we pc_en pc_sel rf_we wb_sel halted err
  localparam logic [10:0] O_ZERO   = 11'b0_0_0_0_00_0_00_0_0;
  localparam logic [10:0] O_IF     = 11'b1_0_0_0_00_0_00_0_0;
  localparam logic [10:0] O_MRD    = 11'b0_1_0_0_00_0_00_0_0;
  localparam logic [10:0] O_MWR    = 11'b0_1_1_0_00_0_00_0_0;
  localparam logic [10:0] O_WB_ALU = 11'b0_0_0_1_00_1_00_0_0;
  localparam logic [10:0] O_WB_LW  = 11'b0_0_0_1_00_1_01_0_0;
  localparam logic [10:0] O_WB_SW  = 11'b0_0_0_1_00_0_00_0_0;
  localparam logic [10:0] O_WB_JR  = 11'b0_0_0_1_10_1_10_0_0;
  localparam logic [10:0] O_BEQ_T  = 11'b0_0_0_1_01_0_00_0_0;
  localparam logic [10:0] O_BEQ_N  = 11'b0_0_0_1_00_0_00_0_0;
  localparam logic [10:0] O_HALT   = 11'b0_0_0_0_00_0_00_1_0;
  localparam logic [10:0] O_HRUN   = 11'b0_0_0_1_00_0_00_1_0;
  localparam logic [10:0] O_ERR    = 11'b0_0_0_0_00_0_00_0_1;

  function automatic logic [10:0] outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc_en, bus.pc_sel,
            bus.rf_we, bus.wb_sel, bus.halted, bus.err};
  endfunction

  task automatic chk_ir(input string tag, input logic [15:0] exp);
    checks++;
    assert (bus.ir === exp) else begin
      errors++;
      $error("FAIL %s: ir got %h expected %h", tag, bus.ir, exp);
    end
  endtask

  // Check this cycle's outputs with the current inputs, then advance a clock.
  task automatic cycle(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    #1;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs got %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    cycle(tag, O_IF);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
  endtask

  initial begin
    rst            = 1'b1;
    bus.run        = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack   = 1'b0;
    bus.eq         = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cycle("reset", O_ZERO);
    chk_ir("reset_ir", 16'h0000);
    rst = 1'b0;
    cycle("idle_hold", O_ZERO);

    // addi: FETCH, DECODE, EXEC, WB
    bus.run = 1'b1;
    cycle("idle_run", O_ZERO);
    bus.run = 1'b0;
    fetch("addi_fetch", 16'h2085);
    chk_ir("addi_ir", 16'h2085);
    cycle("addi_dec", O_ZERO);
    cycle("addi_exec", O_ZERO);
    cycle("addi_wb", O_WB_ALU);

    // lw with ack on the 3rd request cycle
    fetch("lw_fetch", 16'hA081);
    cycle("lw_dec", O_ZERO);
    cycle("lw_exec", O_ZERO);
    cycle("lw_mem1", O_MRD);
    cycle("lw_mem2", O_MRD);
    bus.dmem_ack = 1'b1;
    cycle("lw_mem3", O_MRD);
    bus.dmem_ack = 1'b0;
    cycle("lw_wb", O_WB_LW);

    // sw with the same delay
    fetch("sw_fetch", 16'h8081);
    cycle("sw_dec", O_ZERO);
    cycle("sw_exec", O_ZERO);
    cycle("sw_mem1", O_MWR);
    cycle("sw_mem2", O_MWR);
    bus.dmem_ack = 1'b1;
    cycle("sw_mem3", O_MWR);
    bus.dmem_ack = 1'b0;
    chk_ir("sw_ir", 16'h8081);
    cycle("sw_wb", O_WB_SW);

    // beq taken; eq outside EXEC has no effect
    fetch("beq_t_fetch", 16'hC07F);
    bus.eq = 1'b1;
    cycle("beq_t_dec", O_ZERO);
    cycle("beq_t_exec", O_BEQ_T);
    bus.eq = 1'b0;

    // beq not taken
    fetch("beq_n_fetch", 16'hC07F);
    cycle("beq_n_dec", O_ZERO);
    cycle("beq_n_exec", O_BEQ_N);

    // jalr
    fetch("jalr_fetch", 16'hE000);
    cycle("jalr_dec", O_ZERO);
    cycle("jalr_exec", O_ZERO);
    cycle("jalr_wb", O_WB_JR);

    // halt and resume
    fetch("halt_fetch", 16'hE001);
    cycle("halt_dec", O_ZERO);
    cycle("halt_exec", O_ZERO);
    cycle("halt_wait1", O_HALT);
    cycle("halt_wait2", O_HALT);
    bus.run = 1'b1;
    cycle("halt_resume", O_HRUN);
    bus.run = 1'b0;

    // watchdog: ack on exactly the 4th request cycle wins
    cycle("wd_req1", O_IF);
    cycle("wd_req2", O_IF);
    cycle("wd_req3", O_IF);
    fetch("wd_req4_ack", 16'h2085);
    cycle("wd_ack_dec", O_ZERO);
    cycle("wd_ack_exec", O_ZERO);
    cycle("wd_ack_wb", O_WB_ALU);

    // watchdog: no ack for 4 cycles raises err
    cycle("wd_to1", O_IF);
    cycle("wd_to2", O_IF);
    cycle("wd_to3", O_IF);
    cycle("wd_to4", O_IF);
    cycle("wd_err", O_ERR);
    bus.run      = 1'b1;
    bus.imem_ack = 1'b1;
    cycle("wd_err_sticky", O_ERR);
    bus.run      = 1'b0;
    bus.imem_ack = 1'b0;

    // reset out of ERR
    rst = 1'b1;
    cycle("err_before_rst", O_ERR);
    rst = 1'b0;
    cycle("rst_from_err", O_ZERO);
    chk_ir("rst_from_err_ir", 16'h0000);

    // reset while dmem_req is pending; late ack ignored
    bus.run = 1'b1;
    cycle("rm_run", O_ZERO);
    bus.run = 1'b0;
    fetch("rm_fetch", 16'hA081);
    cycle("rm_dec", O_ZERO);
    cycle("rm_exec", O_ZERO);
    rst = 1'b1;
    cycle("rm_mem", O_MRD);
    rst = 1'b0;
    bus.dmem_ack = 1'b1;
    cycle("rm_after_rst", O_ZERO);
    chk_ir("rm_ir", 16'h0000);
    bus.dmem_ack = 1'b0;
    cycle("rm_idle", O_ZERO);
    bus.run = 1'b1;
    cycle("rm_restart_run", O_ZERO);
    bus.run = 1'b0;
    cycle("rm_restart_fetch", O_IF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
